clk32m768_divider: RTL and testbench

- Binary clock divider fed by the 32.768 MHz system clock.
- Produces 15 square-wave outputs from 16.384 MHz down to 1 kHz, each at a power-of-two division ratio.
- Tx, Rx and the symbol/sample timing logic use the outputs as divided clocks (clk_16M384, clk_2M048, clk_1M024, ...).
- All outputs derive from a single free-running counter, so they are mutually phase-aligned.

---
 rtl/clk32m768_divider.sv | 51 +++++
 tb/tb_clk32m768_divider.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/clk32m768_divider.sv
// Power-of-two clock divider: one free-running 15-bit counter whose
// register bits drive the 15 divided clocks directly, so all stay phase-aligned.
module clk32m768_divider (
    input  logic clk32M768,
    input  logic rst_32M768,
    output logic clk16M384,
    output logic clk8M192,
    output logic clk4M096,
    output logic clk2M048,
    output logic clk1M024,
    output logic clk512K,
    output logic clk256K,
    output logic clk128K,
    output logic clk64K,
    output logic clk32K,
    output logic clk16K,
    output logic clk8K,
    output logic clk4K,
    output logic clk2K,
    output logic clk1K
);

    logic [14:0] cnt;

    // Wraps 32767 -> 0 naturally; no terminal-count logic needed.
    always_ff @(posedge clk32M768) begin
        if (rst_32M768) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 15'd1;
        end
    end

    // Each output is a flop bit with no decode behind it, so it cannot glitch.
    assign clk16M384 = cnt[0];
    assign clk8M192  = cnt[1];
    assign clk4M096  = cnt[2];
    assign clk2M048  = cnt[3];
    assign clk1M024  = cnt[4];
    assign clk512K   = cnt[5];
    assign clk256K   = cnt[6];
    assign clk128K   = cnt[7];
    assign clk64K    = cnt[8];
    assign clk32K    = cnt[9];
    assign clk16K    = cnt[10];
    assign clk8K     = cnt[11];
    assign clk4K     = cnt[12];
    assign clk2K     = cnt[13];
    assign clk1K     = cnt[14];

endmodule

// File: tb/tb_clk32m768_divider.sv
// Scoreboard bench for clk32m768_divider: a reference counter predicts
// every output vector, plus run-length, alignment, wrap and period checks.
`timescale 1ns/1ps
module tb_clk32m768_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [14:0] outs;

    // 2 ns input period
    always #1 clk = ~clk;

    clk32m768_divider dut (
        .clk32M768 (clk),
        .rst_32M768(rst),
        .clk16M384 (outs[0]),
        .clk8M192  (outs[1]),
        .clk4M096  (outs[2]),
        .clk2M048  (outs[3]),
        .clk1M024  (outs[4]),
        .clk512K   (outs[5]),
        .clk256K   (outs[6]),
        .clk128K   (outs[7]),
        .clk64K    (outs[8]),
        .clk32K    (outs[9]),
        .clk16K    (outs[10]),
        .clk8K     (outs[11]),
        .clk4K     (outs[12]),
        .clk2K     (outs[13]),
        .clk1K     (outs[14])
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [14:0] mcnt = '0;
    logic [14:0] sb[$];
    logic [14:0] cur;
    logic [14:0] prev;
    bit          have_prev;
    bit          mon;

    int  run[15];
    bit  run_ok[15];
    longint t_rise[15];
    bit  t_ok[15];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_mon();
        have_prev = 1'b0;
        for (int k = 0; k < 15; k++) begin
            run[k]    = 0;
            run_ok[k] = 1'b0;
            t_ok[k]   = 1'b0;
        end
    endtask

    task automatic run_len(input int k, input string tag);
        if (cur[k] == prev[k]) begin
            run[k]++;
        end else begin
            if (run_ok[k]) check(tag, run[k], 32'd1 << k);
            run_ok[k] = 1'b1;
            run[k] = 1;
        end
    endtask

    task automatic period(input int k, input string tag, input int ns);
        if (cur[k] && !prev[k]) begin
            if (t_ok[k]) check(tag, 32'($time - t_rise[k]), ns);
            t_rise[k] = $time;
            t_ok[k] = 1'b1;
        end
    endtask

    task automatic monitor();
        if (!have_prev) begin
            have_prev = 1'b1;
            return;
        end
        check("tgl16M", 32'(cur[0] ^ prev[0]), 1);
        run_len(3, "run2M048");
        run_len(4, "run1M024");
        run_len(14, "run1K");
        // A clk1M024 rise is the 01111 -> 10000 carry: all faster bits move with it.
        if (cur[4] && !prev[4])
            check("align", {24'd0, prev[3:0], cur[3:0]}, 32'hF0);
        period(0, "per16M", 4);
        period(3, "per2M", 32);
        period(4, "per1M", 64);
    endtask

    // Drive one cycle, predict, then compare at the following falling edge.
    task automatic step(input logic r);
        logic [14:0] exp;
        rst = r;
        mcnt = r ? 15'd0 : mcnt + 15'd1;
        sb.push_back(mcnt);
        @(posedge clk);
        @(negedge clk);
        cur = outs;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            exp = sb.pop_front();
            check("sb", {17'd0, cur}, {17'd0, exp});
        end
        if (r) clear_mon();
        else if (mon) monitor();
        prev = cur;
    endtask

    task automatic release_seq();
        step(1'b0);
        check("rise16M_e1", 32'(outs[0]), 1);
        check("lo8M_e1", 32'(outs[1]), 0);
        step(1'b0);
        check("rise8M_e2", 32'(outs[1]), 1);
        for (int i = 3; i <= 15; i++) step(1'b0);
        check("lo1M_e15", 32'(outs[4]), 0);
        step(1'b0);
        check("rise1M_e16", 32'(outs[4]), 1);
    endtask

    initial begin
        mon = 1'b0;
        clear_mon();
        for (int i = 0; i < 128; i++) begin
            step(1'b1);
            check("rst_zero", {17'd0, outs}, 0);
        end
        release_seq();
        while (mcnt != 15'd1000) step(1'b0);
        check("mid_hi", 32'(outs[9:5]), 32'h1F);
        step(1'b1);
        check("mid_rst", {17'd0, outs}, 0);
        for (int i = 0; i < 3; i++) step(1'b1);
        mon = 1'b1;
        release_seq();
        for (int i = 16; i < 49200; i++) begin
            step(1'b0);
            if (mcnt == 15'h7FFF) begin
                check("wrap_ones", {17'd0, outs}, 32'h7FFF);
                step(1'b0);
                check("wrap_zero", {17'd0, outs}, 0);
                step(1'b0);
                check("wrap_rise", {17'd0, outs}, 1);
                i += 2;
            end
        end
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
